// File: rtl/reset_sequencer_pkg.sv
// Shared definitions for the reset sequencer: parameter defaults, the
// sequencer state enum and a counter-width helper.
package reset_sequencer_pkg;

  localparam int unsigned DefaultStretchCycles  = 1024;
  localparam int unsigned DefaultPeriphLead     = 16;
  localparam int unsigned DefaultDebounceCycles = 4800;

  typedef enum logic [1:0] {
    StWaitLock,
    StStretch,
    StPeriphOnly,
    StRun
  } seq_state_e;

  // Bits needed to hold values 0..max_val (at least one bit).
  function automatic int unsigned cnt_width(int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// 1-bit two-flop synchronizer with synchronous active-high reset to 0.
// Ports:
//   clk   - destination clock
//   reset - synchronous active-high reset, clears both flops
//   d     - asynchronous input
//   q     - synchronized output (two clk edges of latency)
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b0;
      q      <= 1'b0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Power-on / button reset sequencer. Waits for a stable PLL lock, then
// releases the peripheral reset, and PERIPH_LEAD cycles later the CPU reset.
// Any lock loss or debounced button press restarts the whole sequence.
// Ports:
//   clk             - CPU-domain clock, the only clock
//   reset           - synchronous active-high block reset
//   pll_locked      - PLL lock flag, asynchronous
//   btn_reset       - user reset button, asynchronous, may bounce
//   periph_reset    - registered active-high peripheral reset
//   cpu_reset       - registered active-high CPU reset
//   ready           - high only while both resets are released
//   lock_loss_count - saturating count of lock losses after periph release
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int unsigned STRETCH_CYCLES  = DefaultStretchCycles,
  parameter int unsigned PERIPH_LEAD     = DefaultPeriphLead,
  parameter int unsigned DEBOUNCE_CYCLES = DefaultDebounceCycles
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pll_locked,
  input  logic       btn_reset,
  output logic       periph_reset,
  output logic       cpu_reset,
  output logic       ready,
  output logic [7:0] lock_loss_count
);

  // One phase counter serves both STRETCH and PERIPH_ONLY.
  localparam int unsigned PhaseMax =
      ((STRETCH_CYCLES > PERIPH_LEAD) ? STRETCH_CYCLES : PERIPH_LEAD) - 1;
  localparam int unsigned PhaseW = cnt_width(PhaseMax);
  localparam int unsigned DebW   = cnt_width(DEBOUNCE_CYCLES);

  localparam logic [PhaseW-1:0] StretchLast = PhaseW'(STRETCH_CYCLES - 1);
  localparam logic [PhaseW-1:0] LeadLast    = PhaseW'(PERIPH_LEAD - 1);
  localparam logic [DebW-1:0]   DebLast     = DebW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DebW-1:0]   DebFull     = DebW'(DEBOUNCE_CYCLES);

  logic locked_s, btn_s, btn_req, abort;

  seq_state_e        state_q, state_d;
  logic [PhaseW-1:0] phase_q, phase_d;
  logic [DebW-1:0]   deb_q, deb_d;
  logic [7:0]        loss_q, loss_d;
  logic              periph_q, periph_d;
  logic              cpu_q, cpu_d;
  logic              ready_q, ready_d;

  sync_2ff u_sync_lock (
    .clk   (clk),
    .reset (reset),
    .d     (pll_locked),
    .q     (locked_s)
  );

  sync_2ff u_sync_btn (
    .clk   (clk),
    .reset (reset),
    .d     (btn_reset),
    .q     (btn_s)
  );

  // Debounce: counter parks at DEBOUNCE_CYCLES so the request fires once per press.
  always_comb begin
    deb_d = deb_q;
    if (!btn_s) begin
      deb_d = '0;
    end else if (deb_q != DebFull) begin
      deb_d = deb_q + DebW'(1);
    end
  end

  assign btn_req = btn_s && (deb_q == DebLast);
  assign abort   = !locked_s || btn_req;

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    loss_d  = loss_q;
    case (state_q)
      StWaitLock: begin
        if (locked_s && !btn_req) begin
          state_d = StStretch;
          phase_d = '0;
        end
      end
      StStretch: begin
        if (abort) begin
          state_d = StWaitLock;
          phase_d = '0;
        end else if (phase_q == StretchLast) begin
          state_d = StPeriphOnly;
          phase_d = '0;
        end else begin
          phase_d = phase_q + PhaseW'(1);
        end
      end
      StPeriphOnly, StRun: begin
        if (abort) begin
          state_d = StWaitLock;
          phase_d = '0;
          // Only lock loss counts, even when the button fires in the same cycle.
          if (!locked_s && loss_q != 8'hFF) begin
            loss_d = loss_q + 8'd1;
          end
        end else if (state_q == StPeriphOnly) begin
          if (phase_q == LeadLast) begin
            state_d = StRun;
            phase_d = '0;
          end else begin
            phase_d = phase_q + PhaseW'(1);
          end
        end
      end
      default: begin
        state_d = StWaitLock;
        phase_d = '0;
      end
    endcase
  end

  // Outputs are a pure function of the next state, registered alongside it.
  always_comb begin
    periph_d = (state_d == StWaitLock) || (state_d == StStretch);
    cpu_d    = (state_d != StRun);
    ready_d  = (state_d == StRun);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StWaitLock;
      phase_q  <= '0;
      deb_q    <= '0;
      loss_q   <= '0;
      periph_q <= 1'b1;
      cpu_q    <= 1'b1;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      deb_q    <= deb_d;
      loss_q   <= loss_d;
      periph_q <= periph_d;
      cpu_q    <= cpu_d;
      ready_q  <= ready_d;
    end
  end

  assign periph_reset    = periph_q;
  assign cpu_reset       = cpu_q;
  assign ready           = ready_q;
  assign lock_loss_count = loss_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: directed scenarios plus randomized lock/button
// traffic, checked every cycle against a progress-counter reference model.
module tb_reset_sequencer;

  localparam int STRETCH  = 8;
  localparam int LEAD     = 4;
  localparam int DEBOUNCE = 5;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pll_locked = 1'b0;
  logic       btn_reset = 1'b0;
  logic       periph_reset, cpu_reset, ready;
  logic [7:0] lock_loss_count;

  reset_sequencer #(
    .STRETCH_CYCLES  (STRETCH),
    .PERIPH_LEAD     (LEAD),
    .DEBOUNCE_CYCLES (DEBOUNCE)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .pll_locked      (pll_locked),
    .btn_reset       (btn_reset),
    .periph_reset    (periph_reset),
    .cpu_reset       (cpu_reset),
    .ready           (ready),
    .lock_loss_count (lock_loss_count)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_err  = 0;
  int edge_n = 0;

  // Reference model: prog = -1 while waiting for lock, otherwise cycles of
  // uninterrupted progress since the sequence started (saturates at STRETCH+LEAD).
  int prog    = -1;
  int brun    = 0;
  int m_count = 0;
  bit s1 = 0, s2 = 0, b1 = 0, b2 = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h (edge %0d, t=%0t)",
               tag, obs, exp, edge_n, $time);
    end
  endtask

  function automatic logic [10:0] exp_vec();
    logic [7:0] c;
    c = m_count[7:0];
    return {(prog < STRETCH), (prog < STRETCH + LEAD), (prog >= STRETCH + LEAD), c};
  endfunction

  task automatic model_edge();
    bit lk, req;
    if (reset) begin
      prog = -1; brun = 0; m_count = 0;
      s1 = 0; s2 = 0; b1 = 0; b2 = 0;
      return;
    end
    lk   = s2;
    req  = b2 && (brun == DEBOUNCE - 1);
    brun = b2 ? brun + 1 : 0;
    s2 = s1; s1 = pll_locked;
    b2 = b1; b1 = btn_reset;
    if (prog < 0) begin
      if (lk && !req) prog = 0;
    end else if (!lk || req) begin
      if (!lk && prog >= STRETCH && m_count < 255) m_count++;
      prog = -1;
    end else if (prog < STRETCH + LEAD) begin
      prog++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    if (reset) edge_n = 0;
    else edge_n++;
    #1;
    check_val("outputs", {periph_reset, cpu_reset, ready, lock_loss_count}, exp_vec());
    check_val("order", 32'(periph_reset & ~cpu_reset), 0);
  endtask

  task automatic wait_run();
    for (int i = 0; i < 200 && prog < STRETCH + LEAD; i++) step();
    check_val("reach_run", 32'(ready), 1);
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    repeat (cycles) step();
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int burst;
    // Reset state and nominal release timing.
    do_reset(3);
    check_val("rst_state", {periph_reset, cpu_reset, ready, lock_loss_count}, 11'b110_0000_0000);
    while (edge_n < 9) step();
    pll_locked = 1'b1;
    while (edge_n < 19) step();
    check_val("periph_hold_e19", 32'(periph_reset), 1);
    step();
    check_val("periph_rel_e20", 32'(periph_reset), 0);
    check_val("cpu_hold_e20", 32'(cpu_reset), 1);
    while (edge_n < 23) step();
    check_val("ready_e23", 32'(ready), 0);
    step();
    check_val("cpu_rel_e24", 32'(cpu_reset), 0);
    check_val("ready_e24", 32'(ready), 1);

    // One-cycle lock glitch during STRETCH restarts the full sequence.
    pll_locked = 1'b0;
    do_reset(2);
    while (edge_n < 9) step();
    pll_locked = 1'b1;
    while (edge_n < 14) step();
    pll_locked = 1'b0;
    step();
    pll_locked = 1'b1;
    while (edge_n < 25) step();
    check_val("glitch_periph_e25", 32'(periph_reset), 1);
    step();
    check_val("glitch_periph_e26", 32'(periph_reset), 0);
    while (edge_n < 29) step();
    check_val("glitch_cpu_e29", 32'(cpu_reset), 1);
    step();
    check_val("glitch_ready_e30", 32'(ready), 1);
    check_val("glitch_count", 32'(lock_loss_count), 0);

    // Lock loss in RUN: resets reassert two edges later, one loss counted.
    repeat (2) step();
    pll_locked = 1'b0;
    step();
    step();
    check_val("loss_ready_n1", 32'(ready), 1);
    step();
    check_val("loss_state_n2", {periph_reset, cpu_reset, ready}, 3'b110);
    check_val("loss_count", 32'(lock_loss_count), 1);
    pll_locked = 1'b1;
    wait_run();

    // Button: 4 high samples ignored, 6 resequence, loss+button counts once.
    btn_reset = 1'b1;
    repeat (4) step();
    btn_reset = 1'b0;
    repeat (10) step();
    check_val("btn4_ready", 32'(ready), 1);
    btn_reset = 1'b1;
    repeat (6) step();
    btn_reset = 1'b0;
    step();
    check_val("btn6_ready", 32'(ready), 0);
    wait_run();
    check_val("btn6_count", 32'(lock_loss_count), 1);
    btn_reset = 1'b1;
    repeat (4) step();
    pll_locked = 1'b0;
    step();
    btn_reset = 1'b0;
    pll_locked = 1'b1;
    repeat (2) step();
    check_val("both_count", 32'(lock_loss_count), 2);
    check_val("both_ready", 32'(ready), 0);
    wait_run();

    // Randomized traffic.
    burst = 0;
    for (int i = 0; i < 2500; i++) begin
      pll_locked = ($urandom_range(0, 99) < 97);
      if (burst > 0) begin
        burst--;
      end else if ($urandom_range(0, 59) == 0) begin
        burst = $urandom_range(1, 8);
      end
      btn_reset = (burst > 0) ? ($urandom_range(0, 9) != 0) : 1'b0;
      reset = ($urandom_range(0, 599) == 0);
      step();
    end
    reset = 1'b0;
    btn_reset = 1'b0;
    pll_locked = 1'b1;

    // Saturation of the loss counter, then reset while in RUN.
    for (int i = 0; i < 300; i++) begin
      wait_run();
      pll_locked = 1'b0;
      step();
      pll_locked = 1'b1;
      repeat (2) step();
    end
    check_val("sat_count", 32'(lock_loss_count), 255);
    wait_run();
    reset = 1'b1;
    step();
    check_val("rst_run_count", 32'(lock_loss_count), 0);
    check_val("rst_run_state", {periph_reset, cpu_reset, ready}, 3'b110);
    reset = 1'b0;
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 SHALL have parameter STRETCH_CYCLES, default 1024, cycles of stable lock required before any reset release (>=1).
REQ-002 SHALL have parameter PERIPH_LEAD, default 16, cycles peripherals leave reset before the CPU (>=1).
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 4800, consecutive high samples needed to accept a button reset (>=1).
REQ-004 SHALL have port clk  input  1  CPU-domain clock (48 MHz PLL output); the only clock.
REQ-005 SHALL have port reset  input  1  synchronous, active-high block reset.
REQ-006 SHALL have port pll_locked  input  1  PLL lock flag, asynchronous to clk.
REQ-007 SHALL have port btn_reset  input  1  user reset button, active-high, asynchronous, may bounce.
REQ-008 SHALL have port periph_reset  output  1  active-high peripheral reset, registered.
REQ-009 SHALL have port cpu_reset  output  1  active-high CPU reset, registered.
REQ-010 SHALL have port ready  output  1  high only while both resets are released.
REQ-011 SHALL have port lock_loss_count  output  8  saturating count of lock losses since reset.

Function
REQ-012 SHALL pass pll_locked and btn_reset each through a two-flop synchronizer (locked_s, btn_s).
REQ-013 SHALL assert btn_req for one cycle when btn_s has been high for DEBOUNCE_CYCLES consecutive cycles; any low sample clears the debounce counter; btn_req does not repeat until btn_s goes low.
REQ-014 SHALL implement a Moore FSM with states WAIT_LOCK, STRETCH, PERIPH_ONLY, RUN; outputs decode from the state register only.
REQ-015 SHALL drive in WAIT_LOCK and STRETCH: periph_reset=1, cpu_reset=1, ready=0; PERIPH_ONLY: periph_reset=0, cpu_reset=1, ready=0; RUN: 0, 0, 1.
REQ-016 SHALL move WAIT_LOCK -> STRETCH when locked_s=1 and btn_req=0, clearing the stretch counter.
REQ-017 SHALL in STRETCH count cycles with locked_s=1 and move to PERIPH_ONLY on the STRETCH_CYCLES-th such cycle; pll_locked rising sampled at edge N gives STRETCH after N+2, PERIPH_ONLY after N+2+STRETCH_CYCLES, RUN after N+2+STRETCH_CYCLES+PERIPH_LEAD.
REQ-018 SHALL in PERIPH_ONLY count PERIPH_LEAD cycles, then move to RUN.
REQ-019 SHALL from STRETCH, PERIPH_ONLY or RUN return to WAIT_LOCK on locked_s=0 or btn_req=1, clearing counters; re-entry always restarts the full sequence.
REQ-020 SHALL increment lock_loss_count, saturating at 255, on each locked_s=0 exit from PERIPH_ONLY or RUN; btn_req exits and losses in STRETCH do not count.
REQ-021 SHALL, when locked_s=0 and btn_req=1 in the same cycle, go to WAIT_LOCK and count the lock loss exactly once.
REQ-022 SHALL never release cpu_reset before periph_reset, nor assert periph_reset while cpu_reset is low.
REQ-023 SHALL size counters to fit their parameter; no wrap-around inside a sequence.

Reset
REQ-024 SHALL, with reset=1 at a clk edge, take priority over all inputs: state=WAIT_LOCK, all counters and synchronizer flops 0, lock_loss_count=0, periph_reset=1, cpu_reset=1, ready=0 after that edge.
REQ-025 SHALL, after reset deasserts mid-sequence, restart from WAIT_LOCK with no retained progress.

Structure
REQ-026 SHALL place the FSM state enum and the three parameter defaults in the shared SoC package.
REQ-027 SHALL use one sub-module, sync_2ff (1-bit two-flop synchronizer, synchronous reset to 0), instantiated twice.

Verification (STRETCH_CYCLES=8, PERIPH_LEAD=4, DEBOUNCE_CYCLES=5)
REQ-028 SHALL test: reset released, pll_locked high from edge 10 -> periph_reset falls after edge 20, cpu_reset falls and ready rises after edge 24.
REQ-029 SHALL test: pll_locked low for 1 cycle at edge 15 (in STRETCH) -> return to WAIT_LOCK, release delayed by full 8+4 cycles from relock, count stays 0.
REQ-030 SHALL test: in RUN, pll_locked low at edge N -> resets high and ready low after edge N+2, lock_loss_count=1.
REQ-031 SHALL test: btn_reset high 4 cycles -> no effect; high 5+ cycles -> full resequence, count unchanged; loss plus btn_req same cycle -> count +1.
REQ-032 SHALL test: 300 lock-loss events from RUN -> lock_loss_count=255; reset asserted in RUN -> next edge count=0, both resets high, ready=0.
